// File: rtl/soup_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soup_gen : xorshift32-driven random cell soup generator (INIT x INIT cells)
// Optional macro SOUP_DENSITY_EN enables the data[33:32] density select.
// Rev 1.0
// ----------------------------------------------------------------------------
module soup_gen #(
  parameter int INIT = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   brk,
  input  logic                   run,
  input  logic [33:0]            data,
  output logic                   busy,
  output logic                   done,
  output logic [INIT*INIT+31:0]  out
);

  localparam int NI = INIT * INIT;
  localparam int IW = $clog2(NI) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t          state, state_next;
  logic [31:0]     x, x_step, seed_reg;
  logic [NI-1:0]   soup;
  logic [IW-1:0]   idx;
  logic            bit_val;
  logic            start, last;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign x_step = xs(x);
  assign start  = (state == IDLE) && run && !brk;
  assign last   = (state == GEN) && (idx == IW'(NI - 1));
  assign out    = {seed_reg, soup};

`ifdef SOUP_DENSITY_EN
  logic [1:0] density;

  always_comb begin
    bit_val = x_step[0];
    case (density)
      2'b01:   bit_val = x_step[0] & x_step[1];
      2'b10:   bit_val = x_step[0] | x_step[1];
      2'b11:   bit_val = x_step[0] & x_step[1] & x_step[2];
      default: bit_val = x_step[0];
    endcase
  end
`else
  logic unused_density;
  assign unused_density = ^data[33:32];
  assign bit_val        = x_step[0];
`endif

  always_comb begin
    state_next = state;
    if (brk) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (run)  state_next = GEN;
        GEN:     if (last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      x        <= 32'h0000_0001;
      idx      <= '0;
      soup     <= '0;
      seed_reg <= '0;
`ifdef SOUP_DENSITY_EN
      density  <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      if (brk) begin
        busy <= 1'b0;
      end else if (start) begin
        seed_reg <= data[31:0];
        // A zero seed would lock xorshift at zero forever
        x        <= (data[31:0] == 32'd0) ? 32'h0000_0001 : data[31:0];
`ifdef SOUP_DENSITY_EN
        density  <= data[33:32];
`endif
        soup     <= '0;
        idx      <= '0;
        busy     <= 1'b1;
      end else if (state == GEN) begin
        x                <= x_step;
        soup[idx[IW-2:0]] <= bit_val;
        idx              <= idx + IW'(1);
        if (last) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/soup_gen.md
SOUP_GEN -- requirements
Module: soup_gen

Interface
REQ-001 Parameter INIT, default 20: soup edge length; NI = INIT*INIT cells.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 break  input  1  abort pulse from the UART receiver; 1 clock wide.
REQ-005 run  input  1  start pulse from the UART receiver; 1 clock wide, qualifies data.
REQ-006 data  input  34  data[31:0] seed, data[33:32] density select; valid only when run=1.
REQ-007 busy  output  1  high while generating.
REQ-008 done  output  1  1-clock pulse when the soup is complete.
REQ-009 out  output  NI+32  {seed_reg[31:0], soup[NI-1:0]}: soup in bits [NI-1:0], the original seed in bits [NI+31:NI]; feeds the UART transmitter data port.

Function
REQ-010 States: IDLE and GEN only.
REQ-011 IDLE, run=1, break=0: capture data[31:0] into seed_reg.
REQ-012 On the same IDLE start edge, load x <= data[31:0], or 32'h00000001 if data[31:0]==0.
REQ-013 On the same IDLE start edge, capture density <= data[33:32], clear soup to all-zero, set idx <= 0, busy <= 1, and enter GEN.
REQ-014 Step function xs(v): v ^= v<<13; v ^= v>>17; v ^= v<<5; 32-bit, overflow discarded.
REQ-015 Each GEN clock: x <= xs(x); soup[idx] <= f(xs(x)); idx <= idx+1.
REQ-016 f(y) by density: 00 -> y[0] (50%); 01 -> y[0]&y[1] (25%); 10 -> y[0]|y[1] (75%); 11 -> y[0]&y[1]&y[2] (12.5%).
REQ-017 GEN edge writing idx==NI-1: set done <= 1 and busy <= 0, go IDLE.
REQ-018 done is high for exactly one clock, NI clocks after the run-sampling edge.
REQ-019 done <= 0 on every edge other than the one in REQ-017.
REQ-020 idx width: ceil(log2(NI))+1 bits; must not wrap before NI-1.
REQ-021 run during GEN: ignored; generation continues undisturbed.
REQ-022 break in any state: go IDLE, busy <= 0, done <= 0.
REQ-023 On break, the soup and seed_reg hold their partial contents; no done is issued.
REQ-024 run and break in the same clock: break wins; no start.
REQ-025 out holds its value in IDLE until the next accepted run.

Reset
REQ-026 reset=1 asynchronously forces: state IDLE, busy=0, done=0, x=32'h1, idx=0, density=0, soup=0, seed_reg=0.
REQ-027 reset asserted mid-GEN: no done is issued; after release, the block waits in IDLE for a new run.

Configuration
REQ-028 Macro SOUP_DENSITY_EN defined: density select per REQ-016.
REQ-029 Macro SOUP_DENSITY_EN undefined: data[33:32] ignored, density register absent, f(y)=y[0] always (50%).

Verification
REQ-030 Seed 1, density 00, INIT=20: run pulse -> busy high next cycle; soup[0]=1 (xs(1)=32'h00042021); done exactly 400 clocks after run edge; out[431:400]=32'h00000001.
REQ-031 Seed 0 vs seed 1, density 00: soup bits identical; out[431:400] differs (0 vs 1).
REQ-032 Seed 32'hDEADBEEF, density 11 (macro on): popcount(soup) within 50+-20 of 400; same seed with macro off: bit-exact match to a 50%-density reference model.
REQ-033 break 100 clocks into GEN -> busy=0 next cycle; no done for 500 clocks; a new run then completes normally.
REQ-034 run and break asserted in the same IDLE cycle -> stays IDLE, busy=0; a second run pulse during GEN -> done timing unchanged (400 clocks after the first run).
REQ-035 Async reset pulse mid-GEN (not clock-aligned) -> all outputs zero immediately; no done after release.
